// File: rtl/tile_sprite_rom.sv
// Procedural 30x30 sprite ROM (cover, flag, mine) for the minesweeper display.
// Decodes tile-relative row/col combinationally and registers the 12-bit RGB colour.
module tile_sprite_rom #(
    parameter int          TILE         = 30,
    parameter logic [11:0] OUT_OF_RANGE = 12'h000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  sel,
    input  logic [9:0]  row,
    input  logic [9:0]  col,
    output logic [11:0] color_data
);

    localparam logic [11:0] LIGHT = 12'hFFF;
    localparam logic [11:0] MID   = 12'hBBB;
    localparam logic [11:0] DARK  = 12'h777;
    localparam logic [11:0] BLACK = 12'h000;
    localparam logic [11:0] RED   = 12'hF00;

    localparam logic [9:0] TILE_W = 10'(TILE);

    logic [11:0]        color_d;
    logic [11:0]        color_q;
    logic               in_range;
    logic [11:0]        cover_color;
    logic [10:0]        diag_sum;
    logic [9:0]         pen_dist;
    logic [9:0]         pen_start;
    logic signed [6:0]  dr;
    logic signed [6:0]  dc;
    logic signed [13:0] dist_sq;

    // Negative tile offsets wrap to large unsigned values and land out of range here.
    assign in_range = (row < TILE_W) && (col < TILE_W);

    // row<3 && col<30-row is the same as row+col<30, likewise for the column edge.
    assign diag_sum = {1'b0, row} + {1'b0, col};

    always_comb begin
        cover_color = MID;
        if (((row < 10'd3) || (col < 10'd3)) && (diag_sum < 11'd30)) begin
            cover_color = LIGHT;
        end else if ((row >= 10'd27) || (col >= 10'd27)) begin
            cover_color = DARK;
        end
    end

    always_comb begin
        pen_dist  = (row >= 10'd9) ? (row - 10'd9) : (10'd9 - row);
        pen_start = 10'd8 + {pen_dist[8:0], 1'b0};
        dr        = $signed({2'b00, row[4:0]}) - 7'sd15;
        dc        = $signed({2'b00, col[4:0]}) - 7'sd15;
        dist_sq   = dr * dr + dc * dc;
    end

    always_comb begin
        color_d = OUT_OF_RANGE;
        if (in_range) begin
            case (sel)
                2'd0: color_d = cover_color;
                2'd1: begin
                    color_d = cover_color;
                    if ((col >= 10'd15) && (col <= 10'd16) && (row >= 10'd6) && (row <= 10'd22)) begin
                        color_d = BLACK;
                    end else if ((row >= 10'd21) && (row <= 10'd23) && (col >= 10'd9) && (col <= 10'd22)) begin
                        color_d = BLACK;
                    end else if ((row >= 10'd6) && (row <= 10'd12) && (col <= 10'd14) && (col >= pen_start)) begin
                        color_d = RED;
                    end
                end
                2'd2: begin
                    if ((row >= 10'd11) && (row <= 10'd12) && (col >= 10'd11) && (col <= 10'd12)) begin
                        color_d = LIGHT;
                    end else if (dist_sq <= 14'sd64) begin
                        color_d = BLACK;
                    end else if (((row == 10'd15) && (col >= 10'd4) && (col <= 10'd26)) ||
                                 ((col == 10'd15) && (row >= 10'd4) && (row <= 10'd26))) begin
                        color_d = BLACK;
                    end else if ((row == 10'd0) || (col == 10'd0)) begin
                        color_d = DARK;
                    end else begin
                        color_d = MID;
                    end
                end
                default: color_d = OUT_OF_RANGE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            color_q <= 12'h000;
        end else begin
            color_q <= color_d;
        end
    end

    assign color_data = color_q;

endmodule

// File: tb/tb_tile_sprite_rom.sv
// Self-checking bench for tile_sprite_rom: directed sprite points, reset, pipelining,
// then a randomized stream compared against an integer reference model.
module tb_tile_sprite_rom;

    logic        clk;
    logic        rst;
    logic [1:0]  sel;
    logic [9:0]  row;
    logic [9:0]  col;
    logic [11:0] color_data;

    int total = 0;
    int bad   = 0;

    tile_sprite_rom dut (
        .clk       (clk),
        .rst       (rst),
        .sel       (sel),
        .row       (row),
        .col       (col),
        .color_data(color_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference colour straight from the sprite drawing rules, in plain integers.
    function automatic logic [11:0] refColor(int s, int r, int c);
        logic [11:0] base;
        int ar;
        if (r >= 30 || c >= 30 || s == 3) return 12'h000;
        if ((r < 3 && c < 30 - r) || (c < 3 && r < 30 - c)) base = 12'hFFF;
        else if (r >= 27 || c >= 27) base = 12'h777;
        else base = 12'hBBB;
        if (s == 0) return base;
        if (s == 1) begin
            ar = (r < 9) ? 9 - r : r - 9;
            if (c >= 15 && c <= 16 && r >= 6 && r <= 22) return 12'h000;
            if (r >= 21 && r <= 23 && c >= 9 && c <= 22) return 12'h000;
            if (r >= 6 && r <= 12 && c <= 14 && c >= 8 + 2 * ar) return 12'hF00;
            return base;
        end
        if (r >= 11 && r <= 12 && c >= 11 && c <= 12) return 12'hFFF;
        if ((r - 15) * (r - 15) + (c - 15) * (c - 15) <= 64) return 12'h000;
        if ((r == 15 && c >= 4 && c <= 26) || (c == 15 && r >= 4 && r <= 26)) return 12'h000;
        if (r == 0 || c == 0) return 12'h777;
        return 12'hBBB;
    endfunction

    task automatic checkOutput(input string tag, input logic [11:0] got, input logic [11:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Drives one pixel request and checks the colour one edge later.
    task automatic applyStimulus(input string tag, input int s, input int r, input int c,
                                 input logic [11:0] exp);
        @(negedge clk);
        sel = 2'(s);
        row = 10'(r);
        col = 10'(c);
        @(posedge clk);
        #1;
        checkOutput(tag, color_data, exp);
    endtask

    logic [11:0] expPending;
    int          rs, rr, rc;

    initial begin
        rst = 1'b1;
        sel = 2'd0;
        row = 10'd0;
        col = 10'd0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_hold", color_data, 12'h000);
        @(negedge clk);
        rst = 1'b0;

        applyStimulus("cover_0_0",   0, 0, 0,   12'hFFF);
        applyStimulus("cover_29_29", 0, 29, 29, 12'h777);
        applyStimulus("cover_2_28",  0, 2, 28,  12'h777);
        applyStimulus("cover_28_2",  0, 28, 2,  12'h777);
        applyStimulus("cover_15_15", 0, 15, 15, 12'hBBB);

        applyStimulus("flag_9_8",    1, 9, 8,   12'hF00);
        applyStimulus("flag_6_14",   1, 6, 14,  12'hF00);
        applyStimulus("flag_6_13",   1, 6, 13,  12'hBBB);
        applyStimulus("flag_pole",   1, 15, 15, 12'h000);
        applyStimulus("flag_base",   1, 22, 10, 12'h000);
        applyStimulus("flag_15_20",  1, 15, 20, 12'hBBB);
        applyStimulus("flag_0_0",    1, 0, 0,   12'hFFF);

        applyStimulus("mine_body",   2, 15, 15, 12'h000);
        applyStimulus("mine_hilite", 2, 11, 11, 12'hFFF);
        applyStimulus("mine_spike",  2, 15, 4,  12'h000);
        applyStimulus("mine_border", 2, 0, 5,   12'h777);
        applyStimulus("mine_1_1",    2, 1, 1,   12'hBBB);

        for (int s = 0; s < 4; s++) begin
            applyStimulus("range_row30",   s, 30, 0,   12'h000);
            applyStimulus("range_col30",   s, 0, 30,   12'h000);
            applyStimulus("range_row1023", s, 1023, 5, 12'h000);
        end
        applyStimulus("reserved_sel", 3, 15, 15, 12'h000);

        // Back-to-back sprite selects at the same pixel must emerge one per clock.
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            sel = 2'(k);
            row = 10'd9;
            col = 10'd8;
            @(posedge clk);
            #1;
            checkOutput("pipe", color_data, (k == 1) ? 12'hF00 : 12'hBBB);
        end

        // Asynchronous reset mid-stream while the output shows DARK.
        applyStimulus("pre_reset", 0, 29, 29, 12'h777);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("reset_async", color_data, 12'h000);
        @(posedge clk);
        #1;
        checkOutput("reset_held", color_data, 12'h000);
        @(negedge clk);
        rst = 1'b0;
        sel = 2'd0;
        row = 10'd15;
        col = 10'd15;
        @(posedge clk);
        #1;
        checkOutput("post_reset", color_data, 12'hBBB);

        // Random stream: new pixel every cycle, previous pixel's colour checked.
        expPending = 12'h000;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if (i > 0) checkOutput("rand", color_data, expPending);
            rs = int'($urandom_range(0, 3));
            rr = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 1023)) : int'($urandom_range(0, 31));
            rc = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 1023)) : int'($urandom_range(0, 31));
            sel = 2'(rs);
            row = 10'(rr);
            col = 10'(rc);
            expPending = refColor(rs, rr, rc);
        end
        @(negedge clk);
        checkOutput("rand_last", color_data, expPending);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
